// File: rtl/lane_serializer_if.sv
// Handshake and data bundle for lane_serializer.
// The upstream producer and the downstream consumer both sit on the master
// side. The serializer itself takes the slave view.
interface lane_serializer_if #(
    parameter int WIDTH = 8
);
    // Input side: one beat of eight lanes.
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] e;
    logic [WIDTH-1:0] f;
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] h;

    // Output side: one lane per transfer.
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [2:0]       out_idx;
    logic             out_last;

    // Per-packet AND reduction results.
    logic             done;
    logic [WIDTH-1:0] and_q;
    logic             red_q;

    modport master (
        output in_valid, a, b, c, d, e, f, g, h, out_ready,
        input  in_ready, out_valid, out_data, out_idx, out_last,
        input  done, and_q, red_q
    );

    modport slave (
        input  in_valid, a, b, c, d, e, f, g, h, out_ready,
        output in_ready, out_valid, out_data, out_idx, out_last,
        output done, and_q, red_q
    );
endinterface

// File: rtl/lane_serializer.sv
// lane_serializer: captures eight WIDTH-bit lanes in one beat. It emits them
// one per transfer in the order a..h, and reports the bitwise AND of the
// lanes plus its 1-bit reduction once the last lane has been sent.
//
// Handshake rule (both ports): a transfer happens on a rising edge where
// valid and ready are both high. Once raised, valid is held, together with
// its data, until that transfer. Ready may be asserted freely.
module lane_serializer #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    lane_serializer_if.slave     bus,
    output logic [1:0]           dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [WIDTH-1:0] lane [8];
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic [2:0]       idx;
    logic [WIDTH-1:0] and_r;
    logic             red_r;

    logic             capture;
    logic             xfer;
    logic             last_lane;
    logic [WIDTH-1:0] cur_lane;

    assign last_lane = (idx == 3'd7);
    assign cur_lane  = lane[idx];
    assign acc_next  = acc & cur_lane;

    // Handshake qualifiers. in_ready is gated by rst so it drops the moment
    // reset is asserted, not one edge later.
    always_comb begin
        capture = 1'b0;
        xfer    = 1'b0;
        if (state == IDLE && !rst && bus.in_valid) begin
            capture = 1'b1;
        end
        if (state == SEND && bus.out_ready) begin
            xfer = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. DONE always lasts exactly one cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (capture) begin
                    state_next = SEND;
                end
            end
            SEND: begin
                if (xfer && last_lane) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Lane registers. They are loaded only on capture, so the inputs may
    // change freely while the packet is sent.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                lane[i] <= '0;
            end
        end else if (capture) begin
            lane[0] <= bus.a;
            lane[1] <= bus.b;
            lane[2] <= bus.c;
            lane[3] <= bus.d;
            lane[4] <= bus.e;
            lane[5] <= bus.f;
            lane[6] <= bus.g;
            lane[7] <= bus.h;
        end
    end

    // Lane index. It advances on each transfer and stops at 7, which is
    // never wrapped within a packet. It returns to 0 as DONE hands back to
    // IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx <= 3'd0;
        end else if (capture) begin
            idx <= 3'd0;
        end else if (xfer && !last_lane) begin
            idx <= idx + 3'd1;
        end else if (state == DONE) begin
            idx <= 3'd0;
        end
    end

    // Running AND of the lanes accepted so far in this packet.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '1;
        end else if (capture) begin
            acc <= '1;
        end else if (xfer) begin
            acc <= acc_next;
        end
    end

    // Published results. They update only on the final transfer, so a new
    // capture leaves the previous packet's results visible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            and_r <= '0;
            red_r <= 1'b0;
        end else if (xfer && last_lane) begin
            and_r <= acc_next;
            red_r <= &acc_next;
        end
    end

    // Output decode. out_data is forced to 0 outside SEND so that reset and
    // idle show a clean bus.
    always_comb begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.out_last  = 1'b0;
        bus.out_data  = '0;
        bus.done      = 1'b0;
        case (state)
            IDLE: begin
                bus.in_ready = !rst;
            end
            SEND: begin
                bus.out_valid = 1'b1;
                bus.out_data  = cur_lane;
                bus.out_last  = last_lane;
            end
            DONE: begin
                bus.done = 1'b1;
            end
            default: begin
                bus.in_ready = 1'b0;
            end
        endcase
    end

    assign bus.out_idx = idx;
    assign bus.and_q   = and_r;
    assign bus.red_q   = red_r;
    assign dbg_state   = state;

endmodule

// File: tb/tb_lane_serializer.sv
// Directed bench for lane_serializer. The inputs are driven 1 ns after each
// rising edge, and the outputs are checked at that same point.
module tb_lane_serializer;

    logic       clk;
    logic       rst;
    logic [1:0] dbg_state;
    int         checks;
    int         failures;

    lane_serializer_if #(.WIDTH(8)) bus_if ();

    lane_serializer #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus_if.slave),
        .dbg_state (dbg_state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] p_bits [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
    logic [7:0] p_ones [8] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    logic [7:0] p_fe   [8] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFE};
    logic [7:0] p_ba   [8] = '{8'hF0, 8'hF1, 8'hF3, 8'hF7, 8'hFF, 8'hF5, 8'hF4, 8'hFC};
    logic [7:0] p_bb   [8] = '{8'h3C, 8'h7E, 8'hFF, 8'hBD, 8'h3D, 8'h3F, 8'hBC, 8'hFC};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_lanes(input logic [7:0] l [8]);
        bus_if.a = l[0]; bus_if.b = l[1]; bus_if.c = l[2]; bus_if.d = l[3];
        bus_if.e = l[4]; bus_if.f = l[5]; bus_if.g = l[6]; bus_if.h = l[7];
    endtask

    // Sends one packet from an IDLE cycle, then checks each lane transfer,
    // the done pulse and the cycle count. If keep_valid is set, in_valid
    // stays high and nxt is presented right after capture. Otherwise the
    // lane inputs are scrambled after capture.
    task automatic run_packet(input string tag, input logic [7:0] l [8],
                              input logic [7:0] nxt [8], input bit keep_valid,
                              input int stall_idx, input int stall_n,
                              input logic [7:0] prev_and, input logic [7:0] exp_and,
                              input logic exp_red);
        logic [7:0] scr [8];
        int cyc;
        check({tag, ".in_ready_idle"}, bus_if.in_ready, 1);
        drive_lanes(l);
        bus_if.in_valid  = 1'b1;
        bus_if.out_ready = 1'b1;
        step();
        if (keep_valid) begin
            drive_lanes(nxt);
        end else begin
            for (int i = 0; i < 8; i++) scr[i] = ~l[i];
            drive_lanes(scr);
            bus_if.in_valid = 1'b0;
        end
        cyc = 1;
        check({tag, ".and_q_held"}, bus_if.and_q, prev_and);
        for (int i = 0; i < 8; i++) begin
            if (i == stall_idx) begin
                bus_if.out_ready = 1'b0;
                for (int s = 0; s < stall_n; s++) begin
                    check({tag, ".stall_valid"}, bus_if.out_valid, 1);
                    check({tag, ".stall_data"}, bus_if.out_data, l[i]);
                    check({tag, ".stall_idx"}, bus_if.out_idx, i);
                    step();
                    cyc++;
                end
                bus_if.out_ready = 1'b1;
            end
            check({tag, ".out_valid"}, bus_if.out_valid, 1);
            check({tag, ".out_idx"}, bus_if.out_idx, i);
            check({tag, ".out_data"}, bus_if.out_data, l[i]);
            check({tag, ".out_last"}, bus_if.out_last, (i == 7) ? 1 : 0);
            check({tag, ".in_ready_send"}, bus_if.in_ready, 0);
            check({tag, ".done_send"}, bus_if.done, 0);
            step();
            cyc++;
        end
        check({tag, ".done"}, bus_if.done, 1);
        check({tag, ".state_done"}, dbg_state, 2);
        check({tag, ".out_valid_done"}, bus_if.out_valid, 0);
        check({tag, ".in_ready_done"}, bus_if.in_ready, 0);
        check({tag, ".and_q"}, bus_if.and_q, exp_and);
        check({tag, ".red_q"}, bus_if.red_q, exp_red);
        check({tag, ".length"}, cyc + 1, 10 + stall_n);
        step();
        check({tag, ".done_drop"}, bus_if.done, 0);
        check({tag, ".out_idx_idle"}, bus_if.out_idx, 0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst = 1'b1;
        bus_if.in_valid  = 1'b1;
        bus_if.out_ready = 1'b1;
        drive_lanes(p_ones);
        step();
        step();

        // Reset state
        check("rst.in_ready", bus_if.in_ready, 0);
        check("rst.out_valid", bus_if.out_valid, 0);
        check("rst.out_data", bus_if.out_data, 0);
        check("rst.out_idx", bus_if.out_idx, 0);
        check("rst.out_last", bus_if.out_last, 0);
        check("rst.done", bus_if.done, 0);
        check("rst.and_q", bus_if.and_q, 0);
        check("rst.red_q", bus_if.red_q, 0);
        check("rst.state", dbg_state, 0);
        bus_if.in_valid = 1'b0;
        rst = 1'b0;
        step();
        check("rel.in_ready", bus_if.in_ready, 1);
        check("rel.out_valid", bus_if.out_valid, 0);

        // Basic, all-ones and single-zero-bit packets
        run_packet("basic", p_bits, p_bits, 1'b0, -1, 0, 8'h00, 8'h00, 1'b0);
        run_packet("ones", p_ones, p_ones, 1'b0, -1, 0, 8'h00, 8'hFF, 1'b1);
        run_packet("fe", p_fe, p_fe, 1'b0, -1, 0, 8'hFF, 8'hFE, 1'b0);

        // Backpressure: three stall cycles at lane 2
        run_packet("bp", p_bits, p_bits, 1'b0, 2, 3, 8'hFE, 8'h00, 1'b0);

        // Back-to-back: in_valid stays high, second capture right after done
        run_packet("b2b_a", p_ba, p_bb, 1'b1, -1, 0, 8'h00, 8'hF0, 1'b0);
        run_packet("b2b_b", p_bb, p_bb, 1'b0, -1, 0, 8'hF0, 8'h3C, 1'b0);

        // Reset while lane 4 is being offered
        drive_lanes(p_bits);
        bus_if.in_valid = 1'b1;
        step();
        bus_if.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check("mid.out_idx_before", bus_if.out_idx, 4);
        check("mid.out_data_before", bus_if.out_data, 8'h10);
        #2 rst = 1'b1;
        #1;
        check("mid.out_valid", bus_if.out_valid, 0);
        check("mid.in_ready", bus_if.in_ready, 0);
        check("mid.out_idx", bus_if.out_idx, 0);
        check("mid.out_data", bus_if.out_data, 0);
        check("mid.done", bus_if.done, 0);
        check("mid.and_q", bus_if.and_q, 0);
        check("mid.red_q", bus_if.red_q, 0);
        step();
        check("mid.done_hold", bus_if.done, 0);
        rst = 1'b0;
        step();
        run_packet("after_rst", p_ones, p_ones, 1'b0, -1, 0, 8'h00, 8'hFF, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
